gpio_ctrl: RTL and testbench
============================

// Module: gpio_ctrl
// PURPOSE
//  Parametrised memory-mapped GPIO peripheral: NUM_OUT output bits, NUM_IN input bits (switches/buttons).
//  Inputs are synchronised, optionally debounced, and edge-detected into sticky capture bits with maskable IRQ.
//  Sits on the MCU's simple register bus beside the CPU; replaces fixed-width ad-hoc PIO instances.
// PARAMETERS
//  NUM_OUT          8       output bit count (1..32)
//  NUM_IN           4       input bit count (1..32), e.g. 3 switches + 1 button
//  OUT_RESET        0       reset value of the output register (NUM_OUT bits)
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before input accepted (10 ms @ 50 MHz), >=2
// PORTS
//  clk_50mhz  in   1        sole clock
//  reset      in   1        synchronous, active-high reset
//  address    in   3        register word address
//  write      in   1        write strobe, one cycle per access
//  writedata  in   32       write data, low bits used
//  read       in   1        read strobe
//  readdata   out  32       read data, valid cycle after read
//  i_in       in   NUM_IN   asynchronous raw inputs
//  o_out      out  NUM_OUT  registered outputs
//  irq        out  1        level interrupt, registered
// BEHAVIOUR
//  Reset (synchronous, active-high): o_out=OUT_RESET, readdata=0, irq=0, sync/filtered/edge_pol/irq_mask/edge_cap=0, primed=0.
//  Register map (unused bits read 0, undefined addresses read 0, writes ignored):
//   0 DATA_IN  RO  filtered inputs          1 DATA_OUT RW  output register
//   2 OUT_SET  WO  o_out |= wd (reads 0)    3 OUT_CLR  WO  o_out &= ~wd (reads 0)
//   4 EDGE_POL RW  per bit 0=rising,1=fall  5 IRQ_MASK RW  per-bit enable
//   6 EDGE_CAP W1C sticky captured edges
//  Read latency 1: readdata registered on read cycle, holds until next read; write and read same cycle both act.
//  o_out changes the cycle after the write; write visible on readback the next read.
//  Input path: 2-flop synchroniser per bit -> filter -> edge detect vs previous filtered value.
//  Filter: per-bit counter; resets when sync==filtered; when sync!=filtered for DEBOUNCE_CYCLES consecutive
//   cycles, filtered<=sync and counter resets. Any glitch shorter than that leaves filtered unchanged.
//  primed: set when every bit's counter has completed one window after reset (or sync==0 everywhere);
//   until primed, filtered loads but edge_cap does not set (no spurious edges at power-up).
//  Edge: bit i sets edge_cap[i] when filtered[i] transitions in direction EDGE_POL[i].
//  Simultaneous W1C and new edge on same bit: set wins. EDGE_POL change: takes effect next cycle, no capture.
//  irq <= |(edge_cap & irq_mask) registered, 1 cycle after capture/mask change.
//  Reset mid-operation: all state returns to reset values in one cycle, in-flight debounce discarded.
// CONFIGURATION
//  GPIO_DEBOUNCE_EN defined: filter as above, counter width $clog2(DEBOUNCE_CYCLES+1).
//  Not defined: filtered = sync output directly (DEBOUNCE_CYCLES ignored, no counters);
//   primed set 2 cycles after reset release; edge latency = sync(2)+1 cycles.
// STRUCTURE
//  gpio_pkg: register address localparams (GPIO_ADDR_DATA_IN..GPIO_ADDR_EDGE_CAP), bus DATA_W=32, ADDR_W=3.
//  Sub-module gpio_debounce: one bit, synchroniser + counter filter + edge pulses, instantiated NUM_IN times via generate.
//  Top gpio_ctrl: register file, read mux, edge capture, irq.
// TESTING (NUM_OUT=8, NUM_IN=4, DEBOUNCE_CYCLES=4, GPIO_DEBOUNCE_EN defined unless noted)
//  1 Reset, OUT_RESET=8'hA5 -> o_out=A5, irq=0, read addr0..6 returns 0/00A5 per map.
//  2 write 1<-0x3C, 2<-0x01, 3<-0x0C -> o_out 3C, 3D, 31; reads of addr2/3 return 0.
//  3 i_in[0] 0->1 held 10 cycles -> DATA_IN bit0=1 after 2+4 cycles; 3-cycle pulse -> no change, no capture.
//  4 IRQ_MASK=1, rising on bit0 -> EDGE_CAP=1, irq=1 next cycle; W1C 1 -> irq=0; W1C same cycle as edge -> bit stays 1.
//  5 EDGE_POL=0x8, bit3 1->0 -> EDGE_CAP=0x8; bit3 0->1 -> no capture; i_in=F at reset release -> no capture.
//  6 GPIO_DEBOUNCE_EN undefined: 1-cycle-stable change on i_in[2] -> DATA_IN bit2 follows after 2 cycles, captured.

Source files
------------

// File: rtl/gpio_pkg.sv
// GPIO peripheral shared definitions: bus geometry and register word addresses.
// Optional feature macro used by the design: GPIO_DEBOUNCE_EN (input debounce filter).
package gpio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  typedef logic [ADDR_W-1:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_ADDR_DATA_IN  = 3'd0;
  localparam gpio_addr_t GPIO_ADDR_DATA_OUT = 3'd1;
  localparam gpio_addr_t GPIO_ADDR_OUT_SET  = 3'd2;
  localparam gpio_addr_t GPIO_ADDR_OUT_CLR  = 3'd3;
  localparam gpio_addr_t GPIO_ADDR_EDGE_POL = 3'd4;
  localparam gpio_addr_t GPIO_ADDR_IRQ_MASK = 3'd5;
  localparam gpio_addr_t GPIO_ADDR_EDGE_CAP = 3'd6;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input bit: 2-flop synchroniser, optional counter filter, edge pulses.
// Macro GPIO_DEBOUNCE_EN: when defined, the synchronised value must differ from the
// accepted value for DebounceCycles consecutive cycles before it is accepted; when
// undefined the synchroniser output is used directly.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   in_i       raw asynchronous input
//   filt_o     accepted (filtered) level
//   rise_o     filtered level rose since last cycle (combinational pulse)
//   fall_o     filtered level fell since last cycle (combinational pulse)
//   settled_o  filtered level agrees with the synchroniser (no window in flight)
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o,
  output logic settled_o
);

  logic sync1_q, sync2_q;
  logic prev_q;
  logic filt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      prev_q  <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchroniser disagrees; any agreement restarts the window.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt      = filt_q;
  assign settled_o = (sync2_q == filt_q);
`else
  assign filt      = sync2_q;
  assign settled_o = 1'b1;
`endif

  assign filt_o = filt;
  assign rise_o = filt & ~prev_q;
  assign fall_o = ~filt & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO peripheral: output register with set/clear aliases, synchronised
// (optionally debounced) inputs, per-bit edge capture with selectable polarity, masked IRQ.
// Macro GPIO_DEBOUNCE_EN selects the debounce filter inside gpio_debounce.
// Ports:
//   clk_50mhz  clock
//   reset      synchronous active-high reset
//   address    register word address
//   write      write strobe        writedata  write data (low bits used)
//   read       read strobe         readdata   registered read data, holds between reads
//   i_in       raw asynchronous inputs
//   o_out      registered outputs
//   irq        registered level interrupt
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned        NUM_OUT         = 8,
  parameter int unsigned        NUM_IN          = 4,
  parameter logic [NUM_OUT-1:0] OUT_RESET       = '0,
  parameter int unsigned        DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk_50mhz,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  address,
  input  logic               write,
  input  logic [DATA_W-1:0]  writedata,
  input  logic               read,
  output logic [DATA_W-1:0]  readdata,
  input  logic [NUM_IN-1:0]  i_in,
  output logic [NUM_OUT-1:0] o_out,
  output logic               irq
);

  logic [NUM_IN-1:0] filt, rise, fall, settled, edge_hit;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    gpio_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i    (clk_50mhz),
      .rst_i    (reset),
      .in_i     (i_in[i]),
      .filt_o   (filt[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .settled_o(settled[i])
    );
  end

  logic [NUM_OUT-1:0] out_q, out_d;
  logic [NUM_IN-1:0]  pol_q, pol_d;
  logic [NUM_IN-1:0]  mask_q, mask_d;
  logic [NUM_IN-1:0]  cap_q, cap_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic               primed_q, primed_d;
  logic [1:0]         boot_q, boot_d;

  logic [NUM_OUT-1:0] wd_out;
  logic [NUM_IN-1:0]  wd_in;
  logic               unused_wd;

  assign wd_out    = writedata[NUM_OUT-1:0];
  assign wd_in     = writedata[NUM_IN-1:0];
  assign unused_wd = ^writedata;

  assign edge_hit = (pol_q & fall) | (~pol_q & rise);

  always_comb begin
    out_d  = out_q;
    pol_d  = pol_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (write) begin
      case (address)
        GPIO_ADDR_DATA_OUT: out_d  = wd_out;
        GPIO_ADDR_OUT_SET:  out_d  = out_q | wd_out;
        GPIO_ADDR_OUT_CLR:  out_d  = out_q & ~wd_out;
        GPIO_ADDR_EDGE_POL: pol_d  = wd_in;
        GPIO_ADDR_IRQ_MASK: mask_d = wd_in;
        GPIO_ADDR_EDGE_CAP: cap_d  = cap_q & ~wd_in;
        default: ;
      endcase
    end
    // Applied after the W1C so a fresh edge wins over a clear in the same cycle.
    if (primed_q) begin
      cap_d = cap_d | edge_hit;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (read) begin
      rdata_d = '0;
      case (address)
        GPIO_ADDR_DATA_IN:  rdata_d[NUM_IN-1:0]  = filt;
        GPIO_ADDR_DATA_OUT: rdata_d[NUM_OUT-1:0] = out_q;
        GPIO_ADDR_EDGE_POL: rdata_d[NUM_IN-1:0]  = pol_q;
        GPIO_ADDR_IRQ_MASK: rdata_d[NUM_IN-1:0]  = mask_q;
        GPIO_ADDR_EDGE_CAP: rdata_d[NUM_IN-1:0]  = cap_q;
        default: ;
      endcase
    end
  end

  // boot_q[1] marks the synchronisers as holding real samples. Capture stays off until
  // every filter agrees with its synchroniser, so the power-up load of a high input is
  // not seen as an edge.
  always_comb begin
    irq_d    = |(cap_q & mask_q);
    boot_d   = {boot_q[0], 1'b1};
    primed_d = primed_q | (boot_q[1] & (&settled));
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      out_q    <= OUT_RESET;
      pol_q    <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      primed_q <= 1'b0;
      boot_q   <= '0;
    end else begin
      out_q    <= out_d;
      pol_q    <= pol_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      primed_q <= primed_d;
      boot_q   <= boot_d;
    end
  end

  assign o_out    = out_q;
  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register-map vector table plus hand-written
// sequences for input latency, glitch rejection, edge capture, IRQ and reset behaviour.
module tb_gpio_ctrl;

`ifdef GPIO_DEBOUNCE_EN
  localparam int FiltLat = 6;  // 2 sync + 4 debounce cycles
`else
  localparam int FiltLat = 2;
`endif

  logic        clk_50mhz = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic [3:0]  i_in;
  logic [7:0]  o_out;
  logic        irq;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_50mhz = ~clk_50mhz;

  gpio_ctrl #(
    .NUM_OUT        (8),
    .NUM_IN         (4),
    .OUT_RESET      (8'hA5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .address  (address),
    .write    (write),
    .writedata(writedata),
    .read     (read),
    .readdata (readdata),
    .i_in     (i_in),
    .o_out    (o_out),
    .irq      (irq)
  );

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk_50mhz);
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    @(negedge clk_50mhz);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic add(input bit w, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] rd, input logic [7:0] o, input string n);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp_rd = rd; v.exp_out = o; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;

    // Register-map vectors: reset values, output aliases, masking of widths, ignored writes.
    add(0, 3'd0, 0, 32'h0,  8'hA5, "rst_data_in");
    add(0, 3'd1, 0, 32'hA5, 8'hA5, "rst_data_out");
    add(0, 3'd2, 0, 32'h0,  8'hA5, "rst_out_set");
    add(0, 3'd3, 0, 32'h0,  8'hA5, "rst_out_clr");
    add(0, 3'd4, 0, 32'h0,  8'hA5, "rst_edge_pol");
    add(0, 3'd5, 0, 32'h0,  8'hA5, "rst_irq_mask");
    add(0, 3'd6, 0, 32'h0,  8'hA5, "rst_edge_cap");
    add(0, 3'd7, 0, 32'h0,  8'hA5, "rst_undef");
    add(1, 3'd1, 32'h3C, 0, 8'h3C, "wr_data_out");
    add(0, 3'd1, 0, 32'h3C, 8'h3C, "rd_data_out");
    add(1, 3'd2, 32'h01, 0, 8'h3D, "wr_out_set");
    add(0, 3'd2, 0, 32'h0,  8'h3D, "rd_out_set");
    add(1, 3'd3, 32'h0C, 0, 8'h31, "wr_out_clr");
    add(0, 3'd3, 0, 32'h0,  8'h31, "rd_out_clr");
    add(0, 3'd1, 0, 32'h31, 8'h31, "rd_after_clr");
    add(1, 3'd7, 32'hFF, 0, 8'h31, "wr_undef");
    add(1, 3'd0, 32'hFF, 0, 8'h31, "wr_ro");
    add(0, 3'd1, 0, 32'h31, 8'h31, "rd_after_ign");
    add(0, 3'd0, 0, 32'h0,  8'h31, "rd_in_after_wr");
    add(1, 3'd4, 32'hFFFF_FFF5, 0, 8'h31, "wr_pol");
    add(0, 3'd4, 0, 32'h5,  8'h31, "rd_pol");
    add(1, 3'd4, 32'h0, 0,  8'h31, "wr_pol0");
    add(0, 3'd4, 0, 32'h0,  8'h31, "rd_pol0");
    add(1, 3'd5, 32'h6, 0,  8'h31, "wr_mask");
    add(0, 3'd5, 0, 32'h6,  8'h31, "rd_mask");
    add(1, 3'd5, 32'h0, 0,  8'h31, "wr_mask0");
    add(1, 3'd1, 32'hABCD_EF12, 0, 8'h12, "wr_wide");
    add(0, 3'd1, 0, 32'h12, 8'h12, "rd_wide");

    reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0; i_in = '0;
    tick(3);
    reset = 1'b0;
    chk("rst_o_out", {24'h0, o_out}, 32'hA5);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    tick(3);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        chk(vecs[i].name, rd, vecs[i].exp_rd);
      end
      chk({vecs[i].name, "_o_out"}, {24'h0, o_out}, {24'h0, vecs[i].exp_out});
    end

    // Input latency on bit0 and its rising-edge capture.
    i_in = 4'b0001;
    tick(FiltLat - 1);
    bus_read(3'd0, rd);
    chk("din_before_lat", rd, 32'h0);
    bus_read(3'd0, rd);
    chk("din_after_lat", rd, 32'h1);
    bus_read(3'd6, rd);
    chk("cap_rise_bit0", rd, 32'h1);
    chk("irq_unmasked_off", {31'h0, irq}, 32'h0);
    bus_write(3'd6, 32'hF);

`ifdef GPIO_DEBOUNCE_EN
    // 3-cycle low glitch on bit0 must be rejected.
    i_in = 4'b0000;
    tick(3);
    i_in = 4'b0001;
    tick(10);
    bus_read(3'd0, rd);
    chk("glitch_din", rd, 32'h1);
    bus_read(3'd6, rd);
    chk("glitch_cap", rd, 32'h0);
`else
    // 1-cycle high pulse on bit2 passes straight through and is captured.
    i_in = 4'b0101;
    tick(1);
    i_in = 4'b0001;
    bus_read(3'd0, rd);
    chk("pulse_din_before", rd, 32'h1);
    bus_read(3'd0, rd);
    chk("pulse_din_after", rd, 32'h5);
    bus_read(3'd6, rd);
    chk("pulse_cap", rd, 32'h4);
    bus_write(3'd6, 32'hF);
`endif

    // IRQ: falling edge ignored at pol=0, rising edge captured, irq latency, W1C.
    bus_write(3'd5, 32'h1);
    i_in = 4'b0000;
    tick(FiltLat + 3);
    bus_read(3'd6, rd);
    chk("fall_ignored", rd, 32'h0);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    i_in = 4'b0001;
    tick(FiltLat + 1);
    chk("irq_lat0", {31'h0, irq}, 32'h0);
    tick(1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    bus_write(3'd6, 32'h1);
    chk("irq_hold_w1c", {31'h0, irq}, 32'h1);
    tick(1);
    chk("irq_clr", {31'h0, irq}, 32'h0);

    // W1C in the same cycle as a new edge: the edge wins.
    i_in = 4'b0000;
    tick(FiltLat + 3);
    i_in = 4'b0001;
    tick(FiltLat);
    bus_write(3'd6, 32'h1);
    bus_read(3'd6, rd);
    chk("w1c_collide", rd, 32'h1);
    bus_write(3'd6, 32'h1);
    bus_read(3'd6, rd);
    chk("w1c_after", rd, 32'h0);

    // Falling polarity on bit3.
    bus_write(3'd4, 32'h8);
    i_in = 4'b1001;
    tick(FiltLat + 3);
    bus_read(3'd6, rd);
    chk("pol_rise_ignored", rd, 32'h0);
    i_in = 4'b0001;
    tick(FiltLat + 3);
    bus_read(3'd6, rd);
    chk("pol_fall_cap", rd, 32'h8);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    bus_write(3'd5, 32'h9);
    chk("irq_mask_lat", {31'h0, irq}, 32'h0);
    tick(1);
    chk("irq_mask_on", {31'h0, irq}, 32'h1);

    // Reset mid-operation with all inputs high: no power-up capture.
    i_in  = 4'hF;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("rst2_o_out", {24'h0, o_out}, 32'hA5);
    chk("rst2_irq", {31'h0, irq}, 32'h0);
    chk("rst2_readdata", readdata, 32'h0);
    tick(FiltLat + 6);
    bus_read(3'd6, rd);
    chk("rst2_no_cap", rd, 32'h0);
    bus_read(3'd0, rd);
    chk("rst2_din", rd, 32'hF);
    bus_read(3'd4, rd);
    chk("rst2_pol", rd, 32'h0);
    bus_read(3'd5, rd);
    chk("rst2_mask", rd, 32'h0);
    chk("rst2_irq_late", {31'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
